// File: rtl/cpu_defines.sv
// Shared CPU definitions used by the multiply/divide unit: operation codes,
// the muldiv FSM state encoding and the divide-by-zero result constants.
package cpu_defines;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MSUB  = 3'd6,
    MD_MSUBU = 3'd7
  } Md_op_t;

  typedef enum logic [1:0] {
    MD_S_IDLE = 2'd0,
    MD_S_MUL  = 2'd1,
    MD_S_DIV  = 2'd2,
    MD_S_DONE = 2'd3
  } md_state_t;

  // Divide by zero: LO is filled with this bit, HI returns the dividend.
  localparam logic DIV0_LO_FILL = 1'b1;

  function automatic logic op_is_signed(Md_op_t op);
    return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
  endfunction

  function automatic logic op_is_div(Md_op_t op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring radix-2 divider on unsigned magnitudes.
// One quotient bit per cycle, DATA_W iterations. quotient/remainder show the
// result of the iteration in progress, so they are final while done is high.
module muldiv_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic [DATA_W:0]   rem_sh, trial;

  // One restoring step: shift in the next dividend bit, keep the subtraction if it did not borrow.
  always_comb begin
    rem_sh    = {rem_q, quo_q[DATA_W-1]};
    trial     = rem_sh - {1'b0, dvs_q};
    quotient  = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
    remainder = trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
    done      = (cnt == CW'(1));
  end

  // Iteration counter: loads DATA_W, counts down to zero; zero means idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (abort)        cnt <= '0;
    else if (start)        cnt <= CW'(DATA_W);
    else if (cnt != '0)    cnt <= cnt - CW'(1);
  end

  // Partial remainder / quotient shift register.
  always_ff @(posedge clk) begin
    if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (cnt != '0) begin
      rem_q <= remainder;
      quo_q <= quotient;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit: FSM, multiplier latency pipeline, sign fix-up and
// optional multiply-accumulate. Define MULDIV_ACCUM_EN to enable MADD/MSUB
// accumulation; otherwise those ops behave as plain MULT/MULTU.
import cpu_defines::*;

module muldiv_unit #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  Md_op_t            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              cancel,
  output logic              busy_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int W2  = 2 * DATA_W;
  localparam int MCW = $clog2(MUL_CYCLES + 1);

  md_state_t         state, state_nxt;
  logic              accept, div_start, mul_fin, div_fin, div_done;
  logic [MCW-1:0]    mul_cnt;
  Md_op_t            op_p0;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic              neg_q_p0, neg_r_p0;
  logic [W2-1:0]     mul_now, mul_pipe;
  logic [DATA_W-1:0] div_q, div_r;

  function automatic logic [DATA_W-1:0] mag(logic [DATA_W-1:0] v, logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  // Signed ops multiply magnitudes and negate the full product when signs differ.
  function automatic logic [W2-1:0] mul_core(Md_op_t o, logic [DATA_W-1:0] x, logic [DATA_W-1:0] y);
    logic          sgn;
    logic [W2-1:0] p;
    sgn = op_is_signed(o);
    p   = W2'(mag(x, sgn)) * W2'(mag(y, sgn));
    if (sgn && (x[DATA_W-1] ^ y[DATA_W-1])) p = -p;
    return p;
  endfunction

`ifdef MULDIV_ACCUM_EN
  logic [W2-1:0] base_p0;

  function automatic logic [W2-1:0] accum(Md_op_t o, logic [W2-1:0] base, logic [W2-1:0] p);
    if (o inside {MD_MADD, MD_MADDU})      return base + p;
    else if (o inside {MD_MSUB, MD_MSUBU}) return base - p;
    else                                   return p;
  endfunction
`else
  logic unused_acc;
  assign unused_acc = ^{hi_i, lo_i};
`endif

  // Product from the live inputs (single-cycle build) and from the captured operands.
  always_comb begin
    mul_now  = mul_core(op, a, b);
    mul_pipe = mul_core(op_p0, a_p0, b_p0);
`ifdef MULDIV_ACCUM_EN
    mul_now  = accum(op, {hi_i, lo_i}, mul_now);
    mul_pipe = accum(op_p0, base_p0, mul_pipe);
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and control strobes; cancel overrides everything.
  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    valid_o   = 1'b0;
    accept    = 1'b0;
    div_start = 1'b0;
    mul_fin   = 1'b0;
    div_fin   = 1'b0;
    case (state)
      MD_S_IDLE, MD_S_DONE: begin
        valid_o   = (state == MD_S_DONE);
        state_nxt = MD_S_IDLE;
        if (start) begin
          accept = 1'b1;
          if (op_is_div(op)) begin
            if (b == '0) state_nxt = MD_S_DONE;
            else begin
              state_nxt = MD_S_DIV;
              div_start = 1'b1;
            end
          end else begin
            state_nxt = (MUL_CYCLES == 1) ? MD_S_DONE : MD_S_MUL;
          end
        end
      end
      MD_S_MUL: begin
        busy_o = 1'b1;
        if (mul_cnt == MCW'(1)) begin
          mul_fin   = 1'b1;
          state_nxt = MD_S_DONE;
        end
      end
      MD_S_DIV: begin
        busy_o = 1'b1;
        if (div_done) begin
          div_fin   = 1'b1;
          state_nxt = MD_S_DONE;
        end
      end
      default: state_nxt = MD_S_IDLE;
    endcase
    if (cancel) begin
      state_nxt = MD_S_IDLE;
      accept    = 1'b0;
      div_start = 1'b0;
      mul_fin   = 1'b0;
      div_fin   = 1'b0;
    end
  end

  // ---- stage p0: operands and sign flags captured on accept ----
  // Operand capture; datapath registers carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0    <= op;
      a_p0     <= a;
      b_p0     <= b;
      neg_q_p0 <= op_is_signed(op) && (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_r_p0 <= op_is_signed(op) && a[DATA_W-1];
`ifdef MULDIV_ACCUM_EN
      base_p0  <= {hi_i, lo_i};
`endif
    end
  end

  muldiv_divider #(.DATA_W(DATA_W)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (cancel),
    .dividend  (mag(a, op_is_signed(op))),
    .divisor   (mag(b, op_is_signed(op))),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // ---- result stage: HI/LO written on completion, held until the next accept ----
  // Result registers and multiply latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_o    <= '0;
      lo_o    <= '0;
      mul_cnt <= '0;
    end else begin
      if (accept) mul_cnt <= MCW'(MUL_CYCLES - 1);
      else if (state == MD_S_MUL) mul_cnt <= mul_cnt - MCW'(1);

      if (accept && op_is_div(op) && (b == '0)) begin
        hi_o <= a;
        lo_o <= {DATA_W{DIV0_LO_FILL}};
      end else if (accept && !op_is_div(op) && (MUL_CYCLES == 1)) begin
        {hi_o, lo_o} <= mul_now;
      end else if (mul_fin) begin
        {hi_o, lo_o} <= mul_pipe;
      end else if (div_fin) begin
        lo_o <= neg_q_p0 ? -div_q : div_q;
        hi_o <= neg_r_p0 ? -div_r : div_r;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (DATA_W=32, MUL_CYCLES=2).
import cpu_defines::*;

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, cancel;
  Md_op_t      op;
  logic [31:0] a, b, hi_i, lo_i;
  logic        busy_o, valid_o;
  logic [31:0] hi_o, lo_o;

  int passed = 0;
  int total  = 0;

  muldiv_unit #(.DATA_W(32), .MUL_CYCLES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hi_i    (hi_i),
    .lo_i    (lo_i),
    .cancel  (cancel),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait for valid_o; lat is the cycle (1 = first after accept) where it rose.
  task automatic run_op(input Md_op_t o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] hv, input logic [31:0] lv,
                        output int lat, output int nbusy);
    op = o; a = av; b = bv; hi_i = hv; lo_i = lv;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    nbusy = 0;
    while (valid_o !== 1'b1 && lat < 60) begin
      if (busy_o === 1'b1) nbusy++;
      step();
      lat++;
    end
  endtask

  initial begin
    int lat, nb, seen;
    rst = 1'b0; start = 1'b0; cancel = 1'b0; op = MD_MULT;
    a = '0; b = '0; hi_i = '0; lo_i = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk) rst = 1'b0;
    step();

    // MULT -3 * 5
    run_op(MD_MULT, 32'hFFFFFFFD, 32'd5, 0, 0, lat, nb);
    chk("mult_lat", 64'(lat), 64'd2);
    chk("mult_busy", 64'(nb), 64'd1);
    chk("mult_res", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF1);
    step();
    chk("mult_valid_drop", 64'(valid_o), 64'd0);
    chk("mult_hold", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF1);

    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, lat, nb);
    chk("multu_max", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);
    run_op(MD_MULT, 32'h80000000, 32'h80000000, 0, 0, lat, nb);
    chk("mult_minmin", {hi_o, lo_o}, 64'h40000000_00000000);
    run_op(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, lat, nb);
    chk("mult_m1m1", {hi_o, lo_o}, 64'h00000000_00000001);

    // DIVU 100 / 7
    run_op(MD_DIVU, 32'd100, 32'd7, 0, 0, lat, nb);
    chk("divu_lat", 64'(lat), 64'd33);
    chk("divu_busy", 64'(nb), 64'd32);
    chk("divu_res", {hi_o, lo_o}, {32'd2, 32'd14});

    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, lat, nb);
    chk("div_neg7_2", {hi_o, lo_o}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, 0, 0, lat, nb);
    chk("div_7_neg2", {hi_o, lo_o}, {32'd1, 32'hFFFFFFFD});
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, lat, nb);
    chk("div_ovf", {hi_o, lo_o}, {32'd0, 32'h80000000});
    run_op(MD_DIVU, 32'd5, 32'd9, 0, 0, lat, nb);
    chk("divu_small", {hi_o, lo_o}, {32'd5, 32'd0});
    run_op(MD_DIVU, 32'hFFFFFFFF, 32'd1, 0, 0, lat, nb);
    chk("divu_max", {hi_o, lo_o}, {32'd0, 32'hFFFFFFFF});

    // Divide by zero
    run_op(MD_DIV, 32'hFFFFFFF0, 32'd0, 0, 0, lat, nb);
    chk("div0_signed", {hi_o, lo_o}, {32'hFFFFFFF0, 32'hFFFFFFFF});
    run_op(MD_DIVU, 32'h1234, 32'd0, 0, 0, lat, nb);
    chk("div0_lat", 64'(lat), 64'd1);
    chk("div0_busy", 64'(nb), 64'd0);
    chk("div0_res", {hi_o, lo_o}, {32'h1234, 32'hFFFFFFFF});

    // Cancel a divide at cycle 10
    op = MD_DIV; a = 32'd50; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("cancel_busy_before", 64'(busy_o), 64'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel_busy_after", 64'(busy_o), 64'd0);
    chk("cancel_valid_after", 64'(valid_o), 64'd0);
    chk("cancel_hold", {hi_o, lo_o}, {32'h1234, 32'hFFFFFFFF});
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o === 1'b1) seen++;
      step();
    end
    chk("cancel_no_valid", 64'(seen), 64'd0);
    run_op(MD_MULT, 32'd3, 32'd4, 0, 0, lat, nb);
    chk("post_cancel_lat", 64'(lat), 64'd2);
    chk("post_cancel_mult", {hi_o, lo_o}, 64'd12);

    // Start and cancel together: start dropped
    op = MD_MULT; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0;
    chk("startcancel_busy", 64'(busy_o), 64'd0);
    step();
    chk("startcancel_valid", 64'(valid_o), 64'd0);
    chk("startcancel_hold", {hi_o, lo_o}, 64'd12);

    // Start while busy is ignored
    op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 5; i++) step();
    op = MD_MULT; a = 32'd2; b = 32'd2; start = 1'b1;
    step();
    start = 1'b0;
    lat = 6;
    while (valid_o !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
    chk("busy_start_lat", 64'(lat), 64'd33);
    chk("busy_start_res", {hi_o, lo_o}, {32'd2, 32'd14});

    // Accumulate ops
    run_op(MD_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, lat, nb);
`ifdef MULDIV_ACCUM_EN
    chk("maddu", {hi_o, lo_o}, {32'd1, 32'd0});
`else
    chk("maddu", {hi_o, lo_o}, {32'd0, 32'd1});
`endif
    run_op(MD_MSUB, 32'd2, 32'd3, 32'd0, 32'd0, lat, nb);
`ifdef MULDIV_ACCUM_EN
    chk("msub", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFA);
`else
    chk("msub", {hi_o, lo_o}, 64'd6);
`endif

    // Reset in the middle of a divide, then accept on the first edge after release
    op = MD_DIVU; a = 32'd77; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 5; i++) step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk) rst = 1'b0;
    run_op(MD_MULTU, 32'd6, 32'd7, 0, 0, lat, nb);
    chk("postrst_lat", 64'(lat), 64'd2);
    chk("postrst_res", {hi_o, lo_o}, 64'd42);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
